prog_ctr: RTL and testbench

//  Program counter / fetch sequencer; consumes the 10-bit absolute branch target from the branch LUT.

---
 rtl/prog_ctr_pkg.sv | 5 +
 rtl/prog_ctr_sat_counter.sv | 20 ++
 rtl/prog_ctr.sv | 91 +++++++++
 tb/tb_prog_ctr.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/prog_ctr_pkg.sv
// prog_ctr_pkg: shared width and fetch-sequencer state type for the program counter
package prog_ctr_pkg;
  localparam int PC_W = 10;
  typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;
endpackage

// File: rtl/prog_ctr_sat_counter.sv
// prog_ctr_sat_counter: W-bit up counter with synchronous clear (priority) and saturation at all-ones
//  clk, rst : clock, asynchronous active-high reset
//  clr, en  : clear to zero / count enable
//  cnt      : current count
module prog_ctr_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/prog_ctr.sv
// prog_ctr: program counter / fetch sequencer with start/done handshake, jumps, branches, halt and faults
//  Clk, Reset            : clock, asynchronous active-high reset
//  Start, ProgSel        : launch program ProgSel (3 is illegal) from IDLE or HALT
//  Stall, JumpEn         : hold PC / unconditional jump to Target
//  BranchEn, CondFlag    : jump to Target when CondFlag is set
//  HaltReq, Target       : halt at current PC / absolute target from the branch LUT
//  ProgCtr, Busy, Done   : instruction address, RUN and HALT indicators
//  Fault, CycleCount     : sticky range/select fault, saturating RUN-cycle count
module prog_ctr #(
  parameter int PC_W       = prog_ctr_pkg::PC_W,
  parameter int IMEM_DEPTH = 1024,
  parameter int START0     = 0,
  parameter int START1     = 256,
  parameter int START2     = 512,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Stall,
  input  logic             JumpEn,
  input  logic             BranchEn,
  input  logic             CondFlag,
  input  logic             HaltReq,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Busy,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCount
);
  import prog_ctr_pkg::*;
  // A memory that fills the whole address space cannot be overrun, so range checks vanish.
  localparam bit              CHK  = IMEM_DEPTH < (1 << PC_W);
  localparam logic [PC_W:0]   LIM  = (PC_W+1)'(IMEM_DEPTH);
  localparam logic [PC_W-1:0] LAST = PC_W'(IMEM_DEPTH - 1);
  pc_state_t       st_q, st_d;
  logic [PC_W-1:0] pc_q, pc_d, entry;
  logic            fault_q, fault_d, clr, en, taken;
  assign entry = ProgSel == 2'd0 ? PC_W'(START0) : ProgSel == 2'd1 ? PC_W'(START1) : PC_W'(START2);
  assign taken = JumpEn | (BranchEn & CondFlag);
  always_comb begin
    st_d    = st_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    clr     = 1'b0;
    en      = 1'b0;
    if (st_q == RUN) begin
      en = 1'b1;
      if (HaltReq) st_d = HALT;
      else if (Stall) pc_d = pc_q;
      else if (taken) begin
        if (CHK && {1'b0, Target} >= LIM) begin
          fault_d = 1'b1;
          st_d    = HALT;
        end else pc_d = Target;
      end else if (CHK && pc_q == LAST) begin
        fault_d = 1'b1;
        st_d    = HALT;
      end else pc_d = pc_q + PC_W'(1);
    end else if (Start) begin
      if (ProgSel == 2'd3) begin
        fault_d = 1'b1;
        st_d    = HALT;
      end else begin
        fault_d = 1'b0;
        st_d    = RUN;
        pc_d    = entry;
        clr     = 1'b1;
      end
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      st_q    <= IDLE;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  prog_ctr_sat_counter #(.W(CNT_W)) u_cnt (
    .clk(Clk), .rst(Reset), .clr(clr), .en(en), .cnt(CycleCount)
  );
  assign ProgCtr = pc_q;
  assign Busy    = st_q == RUN;
  assign Done    = st_q == HALT;
  assign Fault   = fault_q;
endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: directed scoreboard bench for prog_ctr (default build and a 128-word / 4-bit-counter build)
module tb_prog_ctr;
  logic       Clk = 1'b0, Reset = 1'b1;
  logic       Start = 1'b0, Stall = 1'b0, JumpEn = 1'b0, BranchEn = 1'b0, CondFlag = 1'b0, HaltReq = 1'b0;
  logic [1:0] ProgSel = 2'd0;
  logic [9:0] Target = '0;
  logic [9:0] pc_a, pc_b;
  logic       busy_a, busy_b, done_a, done_b, fault_a, fault_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  int total = 0, bad = 0;

  typedef struct {
    string       tag;
    int          dut;
    logic [9:0]  pc;
    logic        busy, done, fault;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];

  always #5 Clk = ~Clk;

  prog_ctr u_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall), .JumpEn(JumpEn),
    .BranchEn(BranchEn), .CondFlag(CondFlag), .HaltReq(HaltReq), .Target(Target),
    .ProgCtr(pc_a), .Busy(busy_a), .Done(done_a), .Fault(fault_a), .CycleCount(cnt_a)
  );
  prog_ctr #(.IMEM_DEPTH(128), .CNT_W(4)) u_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall), .JumpEn(JumpEn),
    .BranchEn(BranchEn), .CondFlag(CondFlag), .HaltReq(HaltReq), .Target(Target),
    .ProgCtr(pc_b), .Busy(busy_b), .Done(done_b), .Fault(fault_b), .CycleCount(cnt_b)
  );

  function automatic exp_t mk(input string tag, input int dut, input int pc, input logic busy,
                              input logic done, input logic fault, input int cnt);
    exp_t e;
    e.tag = tag; e.dut = dut; e.pc = pc[9:0]; e.busy = busy; e.done = done; e.fault = fault;
    e.cnt = cnt[15:0];
    return e;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    logic [9:0]  p;
    logic        b, d, f;
    logic [15:0] c;
    if (q.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = q.pop_front();
    if (e.dut == 0) begin
      p = pc_a; b = busy_a; d = done_a; f = fault_a; c = cnt_a;
    end else begin
      p = pc_b; b = busy_b; d = done_b; f = fault_b; c = {12'd0, cnt_b};
    end
    cmp(e.tag, "pc", {6'd0, p}, {6'd0, e.pc});
    cmp(e.tag, "busy", {15'd0, b}, {15'd0, e.busy});
    cmp(e.tag, "done", {15'd0, d}, {15'd0, e.done});
    cmp(e.tag, "fault", {15'd0, f}, {15'd0, e.fault});
    cmp(e.tag, "cnt", c, e.cnt);
  endtask

  task automatic go(input exp_t e);
    q.push_back(e);
    @(posedge Clk);
    #1;
    check_pop();
  endtask

  task automatic now(input exp_t e);
    q.push_back(e);
    check_pop();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    now(mk("rst_init", 0, 0, 0, 0, 0, 0));
    now(mk("rst_init_b", 1, 0, 0, 0, 0, 0));
    // run program 1 up to PC 37, then reset between edges
    Start = 1'b1; ProgSel = 2'd0;
    go(mk("launch0", 0, 0, 1, 0, 0, 0));
    Start = 1'b0;
    for (int i = 1; i <= 37; i++) go(mk("run0", 0, i, 1, 0, 0, i));
    #2 Reset = 1'b1;
    #1;
    now(mk("async_rst", 0, 0, 0, 0, 0, 0));
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    go(mk("idle_after_rst", 0, 0, 0, 0, 0, 0));
    // program 2: entry 256 and five increments
    Start = 1'b1; ProgSel = 2'd1;
    go(mk("launch1", 0, 256, 1, 0, 0, 0));
    Start = 1'b0;
    for (int i = 1; i <= 5; i++) go(mk("run1", 0, 256 + i, 1, 0, 0, i));
    // jumps, branches, stall priority
    JumpEn = 1'b1; Target = 10'd20;
    go(mk("jump20", 0, 20, 1, 0, 0, 6));
    JumpEn = 1'b0; BranchEn = 1'b1; CondFlag = 1'b0;
    go(mk("br_not_taken", 0, 21, 1, 0, 0, 7));
    CondFlag = 1'b1; Target = 10'd100;
    go(mk("br_taken", 0, 100, 1, 0, 0, 8));
    BranchEn = 1'b0; CondFlag = 1'b0; JumpEn = 1'b1; Stall = 1'b1; Target = 10'd300;
    go(mk("stall_over_jump", 0, 100, 1, 0, 0, 9));
    Stall = 1'b0; Target = 10'd110;
    go(mk("jump110", 0, 110, 1, 0, 0, 10));
    HaltReq = 1'b1; Target = 10'd5;
    go(mk("halt", 0, 110, 0, 1, 0, 11));
    HaltReq = 1'b0; JumpEn = 1'b0;
    go(mk("halt_hold", 0, 110, 0, 1, 0, 11));
    Start = 1'b1; ProgSel = 2'd2;
    go(mk("relaunch2", 0, 512, 1, 0, 0, 0));
    Start = 1'b0;
    // full-depth memory wraps without fault; Start ignored in RUN
    JumpEn = 1'b1; Target = 10'd1023;
    go(mk("jump1023", 0, 1023, 1, 0, 0, 1));
    JumpEn = 1'b0;
    go(mk("wrap", 0, 0, 1, 0, 0, 2));
    Start = 1'b1; ProgSel = 2'd0;
    go(mk("start_in_run", 0, 1, 1, 0, 0, 3));
    Start = 1'b0;
    // 128-word build: out-of-range target and running off the end
    do_reset();
    Start = 1'b1; ProgSel = 2'd0;
    go(mk("b_launch", 1, 0, 1, 0, 0, 0));
    Start = 1'b0; JumpEn = 1'b1; Target = 10'd200;
    go(mk("b_bad_target", 1, 0, 0, 1, 1, 1));
    JumpEn = 1'b0;
    go(mk("b_fault_hold", 1, 0, 0, 1, 1, 1));
    Start = 1'b1;
    go(mk("b_relaunch_clr", 1, 0, 1, 0, 0, 0));
    Start = 1'b0; JumpEn = 1'b1; Target = 10'd127;
    go(mk("b_jump127", 1, 127, 1, 0, 0, 1));
    JumpEn = 1'b0;
    go(mk("b_overrun", 1, 127, 0, 1, 1, 2));
    Start = 1'b1; ProgSel = 2'd3;
    go(mk("b_sel3_halt", 1, 127, 0, 1, 1, 2));
    Start = 1'b0;
    // illegal select from IDLE, then held Start relaunches and counter saturation
    do_reset();
    Start = 1'b1; ProgSel = 2'd3;
    go(mk("b_sel3_idle", 1, 0, 0, 1, 1, 0));
    ProgSel = 2'd0;
    go(mk("b_held_launch", 1, 0, 1, 0, 0, 0));
    for (int i = 1; i <= 20; i++) go(mk("b_sat", 1, i, 1, 0, 0, i > 15 ? 15 : i));
    HaltReq = 1'b1;
    go(mk("b_halt_held", 1, 20, 0, 1, 0, 15));
    HaltReq = 1'b0;
    go(mk("b_rehalt_launch", 1, 0, 1, 0, 0, 0));
    go(mk("b_run_held", 1, 1, 1, 0, 0, 1));
    Start = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
